// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master round-robin arbiter for a shared 8-bit Wishbone-style
// slave bus, with a per-grant timeout that aborts a cycle the slave never acks.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   m0_* / m1_*                  master 0 (external bus) / master 1 (sequencer):
//                                stb/we/adr/dat in, dat/ack/err out
//   stb_o, we_o, adr_o, dat_o    shared slave bus, driven from the granted master
//   dat_i, ack_i                 slave read data and acknowledge
//   gnt_o                        one-hot grant (bit0 = m0, bit1 = m1), 0 when idle
//
// state | meaning
// IDLE  | no owner; arbitrate between pending requests
// GNT0  | master 0 owns the slave bus
// GNT1  | master 1 owns the slave bus
module wb_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_adr_i,
  input  logic [7:0] m0_dat_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_adr_i,
  input  logic [7:0] m1_dat_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [7:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  output logic [1:0] gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic       last_gnt, last_gnt_nx;  // 1: m1 was granted last, so m0 wins a tie
  logic [7:0] cnt, cnt_nx;
  logic       expire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      cnt      <= 8'd0;
    end else begin
      state    <= state_nx;
      last_gnt <= last_gnt_nx;
      cnt      <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    cnt_nx      = cnt;
    expire      = 1'b0;
    stb_o       = 1'b0;
    we_o        = 1'b0;
    adr_o       = 8'd0;
    dat_o       = 8'd0;
    gnt_o       = 2'b00;
    m0_ack_o    = 1'b0;
    m0_err_o    = 1'b0;
    m1_ack_o    = 1'b0;
    m1_err_o    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = 8'd0;
        if (m0_stb_i && m1_stb_i)
          state_nx = last_gnt ? GNT0 : GNT1;
        else if (m0_stb_i)
          state_nx = GNT0;
        else if (m1_stb_i)
          state_nx = GNT1;
      end
      GNT0: begin
        // an ack in the final cycle wins over the timeout
        expire   = m0_stb_i && !ack_i && (cnt == CNT_LAST);
        gnt_o    = 2'b01;
        stb_o    = m0_stb_i && !expire;
        we_o     = m0_we_i;
        adr_o    = m0_adr_i;
        dat_o    = m0_dat_i;
        m0_ack_o = m0_stb_i && ack_i;
        m0_err_o = expire;
        if (!m0_stb_i || ack_i || (cnt == CNT_LAST)) begin
          state_nx    = IDLE;
          last_gnt_nx = 1'b0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      GNT1: begin
        expire   = m1_stb_i && !ack_i && (cnt == CNT_LAST);
        gnt_o    = 2'b10;
        stb_o    = m1_stb_i && !expire;
        we_o     = m1_we_i;
        adr_o    = m1_adr_i;
        dat_o    = m1_dat_i;
        m1_ack_o = m1_stb_i && ack_i;
        m1_err_o = expire;
        if (!m1_stb_i || ack_i || (cnt == CNT_LAST)) begin
          state_nx    = IDLE;
          last_gnt_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // read data is broadcast; only the granted master sees an ack qualifying it
  assign m0_dat_o = rst_i ? 8'd0 : dat_i;
  assign m1_dat_o = rst_i ? 8'd0 : dat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int T = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [7:0] m0_adr_i = 8'd0, m0_dat_i = 8'd0;
  logic       m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [7:0] m1_adr_i = 8'd0, m1_dat_i = 8'd0;
  logic [7:0] dat_i = 8'd0;
  logic       ack_i = 1'b0;
  logic [7:0] m0_dat_o, m1_dat_o, adr_o, dat_o;
  logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, stb_o, we_o;
  logic [1:0] gnt_o;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .gnt_o(gnt_o)
  );

  // reference model: who owns the bus, how many granted cycles have elapsed,
  // and which master (0/1) won most recently
  int m_owner = 0;   // 0 none, 1 = m0, 2 = m1
  int m_age   = 0;
  int m_last  = 1;

  logic [39:0] exp_q[$];
  logic [1:0]  gq[$];
  logic        rec_en = 1'b0;
  logic [1:0]  prev_gnt = 2'b00;
  int n_cmp = 0;
  int n_bad = 0;

  // expected {stb,we,adr,dat,gnt,m0_ack,m0_err,m1_ack,m1_err,m0_dat,m1_dat}
  function automatic logic [39:0] predict();
    logic s, a, e;
    if (rst_i) return 40'd0;
    if (m_owner == 1) begin
      s = m0_stb_i;
      a = s && ack_i;
      e = s && !ack_i && (m_age == T - 1);
      return {s && !e, m0_we_i, m0_adr_i, m0_dat_i, 2'b01, a, e, 1'b0, 1'b0, dat_i, dat_i};
    end
    if (m_owner == 2) begin
      s = m1_stb_i;
      a = s && ack_i;
      e = s && !ack_i && (m_age == T - 1);
      return {s && !e, m1_we_i, m1_adr_i, m1_dat_i, 2'b10, 1'b0, 1'b0, a, e, dat_i, dat_i};
    end
    return {24'd0, dat_i, dat_i};
  endfunction

  function automatic void advance();
    logic s;
    if (rst_i) begin
      m_owner = 0; m_age = 0; m_last = 1;
    end else if (m_owner == 0) begin
      if (m0_stb_i && m1_stb_i) m_owner = (m_last == 1) ? 1 : 2;
      else if (m0_stb_i)        m_owner = 1;
      else if (m1_stb_i)        m_owner = 2;
      m_age = 0;
    end else begin
      s = (m_owner == 1) ? m0_stb_i : m1_stb_i;
      if (!s || ack_i || (m_age == T - 1)) begin
        m_last  = m_owner - 1;
        m_owner = 0;
      end else begin
        m_age++;
      end
    end
  endfunction

  task automatic step();
    exp_q.push_back(predict());
    @(posedge clk_i);
    advance();
    #1;
  endtask

  task automatic chk_gnt(input int idx, input logic [1:0] want, input string nm);
    n_cmp++;
    if (idx >= gq.size()) begin
      n_bad++;
      $display("FAIL %s grant #%0d missing (only %0d grants seen), required %b", nm, idx, gq.size(), want);
    end else if (gq[idx] !== want) begin
      n_bad++;
      $display("FAIL %s grant #%0d actual=%b required=%b", nm, idx, gq[idx], want);
    end
  endtask

  // monitor: every cycle the DUT presents its outputs, compare with the oldest expectation
  initial begin
    logic [39:0] act, e;
    forever begin
      @(negedge clk_i);
      act = {stb_o, we_o, adr_o, dat_o, gnt_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o};
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, e);
        end
      end
      if (rec_en && gnt_o != 2'b00 && prev_gnt == 2'b00) gq.push_back(gnt_o);
      prev_gnt = gnt_o;
    end
  end

  initial begin
    logic fin;
    @(posedge clk_i); #1;
    repeat (3) step();
    rst_i = 1'b0;

    // both masters requesting, slave acks on the 2nd granted cycle
    gq.delete(); rec_en = 1'b1;
    m0_stb_i = 1; m1_stb_i = 1; m0_adr_i = 8'h10; m1_adr_i = 8'h20; dat_i = 8'h3C;
    repeat (14) begin ack_i = (m_owner != 0 && m_age == 1); step(); end
    rec_en = 1'b0;
    chk_gnt(0, 2'b01, "rr_alternate"); chk_gnt(1, 2'b10, "rr_alternate");
    chk_gnt(2, 2'b01, "rr_alternate"); chk_gnt(3, 2'b10, "rr_alternate");
    m0_stb_i = 0; m1_stb_i = 0; ack_i = 0;
    step(); step();

    // m0 write 0x32 <- 0xA5, ack on 2nd granted cycle
    m0_we_i = 1; m0_adr_i = 8'h32; m0_dat_i = 8'hA5; m0_stb_i = 1;
    for (int i = 0; i < 5; i++) begin
      ack_i = (m_owner == 1 && m_age == 1); step();
      if (ack_i) m0_stb_i = 0;
    end
    ack_i = 0; m0_we_i = 0;

    // m1 read of 0x81 returning 0x5C
    m1_we_i = 0; m1_adr_i = 8'h81; dat_i = 8'h5C; m1_stb_i = 1;
    for (int i = 0; i < 5; i++) begin
      ack_i = (m_owner == 2 && m_age == 1); step();
      if (ack_i) m1_stb_i = 0;
    end
    ack_i = 0;

    // m0 never acked: timeout
    m0_adr_i = 8'h44; m0_stb_i = 1;
    for (int i = 0; i < 8; i++) begin
      fin = (m_owner == 1 && m_age == T - 1); step();
      if (fin) m0_stb_i = 0;
    end

    // m1 acked in the final (timeout) cycle: ack wins
    m1_adr_i = 8'h55; m1_stb_i = 1;
    for (int i = 0; i < 8; i++) begin
      ack_i = (m_owner == 2 && m_age == T - 1); step();
      if (ack_i) m1_stb_i = 0;
    end
    ack_i = 0;

    // m0 drops stb in its 2nd granted cycle while m1 waits
    gq.delete(); rec_en = 1'b1;
    m0_stb_i = 1; m1_stb_i = 1;
    for (int i = 0; i < 8; i++) begin
      if (m_owner == 1 && m_age == 1) m0_stb_i = 0;
      ack_i = (m_owner == 2 && m_age == 0); step();
      if (ack_i) m1_stb_i = 0;
    end
    rec_en = 1'b0; ack_i = 0; m0_stb_i = 0; m1_stb_i = 0;
    chk_gnt(0, 2'b01, "abort_then_m1"); chk_gnt(1, 2'b10, "abort_then_m1");
    step();

    // reset pulsed while in GNT1, then both request: m0 first
    m1_stb_i = 1;
    for (int i = 0; i < 4; i++) if (m_owner != 2) step();
    rst_i = 1; step(); step();
    gq.delete(); rec_en = 1'b1;
    rst_i = 0; m0_stb_i = 1; m1_stb_i = 1;
    repeat (8) begin ack_i = (m_owner != 0 && m_age == 0); step(); end
    rec_en = 1'b0;
    chk_gnt(0, 2'b01, "post_reset_first"); chk_gnt(1, 2'b10, "post_reset_first");

    // randomized traffic
    repeat (600) begin
      rst_i    = ($urandom_range(0, 199) == 0);
      m0_stb_i = ($urandom_range(0, 9) < 7);
      m1_stb_i = ($urandom_range(0, 9) < 6);
      m0_we_i  = 1'($urandom_range(0, 1));
      m1_we_i  = 1'($urandom_range(0, 1));
      m0_adr_i = 8'($urandom); m0_dat_i = 8'($urandom);
      m1_adr_i = 8'($urandom); m1_dat_i = 8'($urandom);
      dat_i    = 8'($urandom);
      ack_i    = ($urandom_range(0, 3) == 0);
      step();
    end
    rst_i = 0; m0_stb_i = 0; m1_stb_i = 0; ack_i = 0;
    step(); step();

    repeat (3) if (exp_q.size() != 0) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
